demux_1_2_27_bits: RTL and testbench

Registered 1-to-2 steering stage for 27-bit mantissa words (24-bit significand plus guard, round and sticky bits). It routes one input stream to one of two downstream floating-point consumers, such as the normalize path and the round path. Its role is the inverse of the 2:1 mantissa select. Each output has a one-entry holding register with a valid/ready handshake, so a stalled consumer never corrupts or blocks traffic already accepted for the other consumer.

---
 rtl/demux_1_2_27_bits.sv | 96 +++++++++
 tb/tb_demux_1_2_27_bits.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_2_27_bits.sv
// Registered 1-to-2 steering stage for 27-bit mantissa words, one holding register per output.
// Optional DEMUX_COUNT_EN adds per-output delivered-word counters (out_0_count, out_1_count).
module demux_1_2_27_bits (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [26:0] in_data,
  input  logic        select,
  output logic        out_0_valid,
  input  logic        out_0_ready,
  output logic [26:0] out_0_data,
  output logic        out_1_valid,
  input  logic        out_1_ready,
  output logic [26:0] out_1_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0] out_0_count,
  output logic [15:0] out_1_count
`endif
);

  // Handshake: a word moves on any edge where valid && ready are both 1 on that
  // interface; the producer holds valid and data stable until that edge.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  chan_state_t state_0_q, state_0_d;
  chan_state_t state_1_q, state_1_d;

  logic take_0, take_1;
  logic drain_0, drain_1;

  // in_ready looks only at the selected channel so the other one can stall freely.
  assign in_ready = select ? (!out_1_valid || out_1_ready)
                           : (!out_0_valid || out_0_ready);

  // in_valid gates first so an unknown select or data while idle is never loaded.
  assign take_0  = in_valid && in_ready && (select == 1'b0);
  assign take_1  = in_valid && in_ready && (select == 1'b1);
  assign drain_0 = out_0_valid && out_0_ready;
  assign drain_1 = out_1_valid && out_1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_0_q  <= EMPTY;
      state_1_q  <= EMPTY;
      out_0_data <= 27'd0;
      out_1_data <= 27'd0;
    end else begin
      state_0_q <= state_0_d;
      state_1_q <= state_1_d;
      if (take_0) out_0_data <= in_data;
      if (take_1) out_1_data <= in_data;
    end
  end

  always_comb begin
    state_0_d = state_0_q;
    case (state_0_q)
      EMPTY:   if (take_0) state_0_d = FULL;
      FULL:    if (drain_0 && !take_0) state_0_d = EMPTY;
      default: state_0_d = EMPTY;
    endcase
  end

  always_comb begin
    state_1_d = state_1_q;
    case (state_1_q)
      EMPTY:   if (take_1) state_1_d = FULL;
      FULL:    if (drain_1 && !take_1) state_1_d = EMPTY;
      default: state_1_d = EMPTY;
    endcase
  end

  // The channel state is visible directly as its valid output.
  always_comb begin
    out_0_valid = (state_0_q == FULL);
    out_1_valid = (state_1_q == FULL);
  end

`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_0_count <= 16'd0;
      out_1_count <= 16'd0;
    end else begin
      if (drain_0) out_0_count <= out_0_count + 16'd1;
      if (drain_1) out_1_count <= out_1_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1_2_27_bits.sv
// Bench for demux_1_2_27_bits: directed scenarios plus randomized traffic against a
// queue-based reference model of the two holding registers.
module tb_demux_1_2_27_bits;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_data;
  logic        select;
  logic        out_0_valid;
  logic        out_0_ready;
  logic [26:0] out_0_data;
  logic        out_1_valid;
  logic        out_1_ready;
  logic [26:0] out_1_data;
`ifdef DEMUX_COUNT_EN
  logic [15:0] out_0_count;
  logic [15:0] out_1_count;
`endif

  int checks;
  int failures;

  // Reference model: each channel holds at most one word awaiting its consumer.
  logic [26:0] exp_q0[$];
  logic [26:0] exp_q1[$];
  logic [26:0] last0, last1;
  logic [15:0] cnt0, cnt1;

  demux_1_2_27_bits dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .select      (select),
    .out_0_valid (out_0_valid),
    .out_0_ready (out_0_ready),
    .out_0_data  (out_0_data),
    .out_1_valid (out_1_valid),
    .out_1_ready (out_1_ready),
    .out_1_data  (out_1_data)
`ifdef DEMUX_COUNT_EN
    ,
    .out_0_count (out_0_count),
    .out_1_count (out_1_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    exp_q0.delete();
    exp_q1.delete();
    last0 = 27'd0;
    last1 = 27'd0;
    cnt0  = 16'd0;
    cnt1  = 16'd0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  // driver: called just after a falling edge
  task automatic drive(input logic iv, input logic sel, input logic [26:0] d,
                       input logic r0, input logic r1);
    in_valid    = iv;
    select      = sel;
    in_data     = d;
    out_0_ready = r0;
    out_1_ready = r1;
    #1;
  endtask

  // advance one clock; the model applies deliveries first, then acceptances
  task automatic tick();
    logic tk0, tk1, dr0, dr1;
    dr0 = (exp_q0.size() != 0) && (out_0_ready === 1'b1);
    dr1 = (exp_q1.size() != 0) && (out_1_ready === 1'b1);
    tk0 = (in_valid === 1'b1) && (select === 1'b0) &&
          ((exp_q0.size() == 0) || (out_0_ready === 1'b1));
    tk1 = (in_valid === 1'b1) && (select === 1'b1) &&
          ((exp_q1.size() == 0) || (out_1_ready === 1'b1));
    @(posedge clk);
    if (dr0) begin void'(exp_q0.pop_front()); cnt0 = cnt0 + 16'd1; end
    if (dr1) begin void'(exp_q1.pop_front()); cnt1 = cnt1 + 16'd1; end
    if (tk0) begin exp_q0.push_back(in_data); last0 = in_data; end
    if (tk1) begin exp_q1.push_back(in_data); last1 = in_data; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 27'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (out_0_valid !== 1'b0 || out_1_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b/%b want 0/0", out_0_valid, out_1_valid);
    end
    checks++;
    if (out_0_data !== 27'd0 || out_1_data !== 27'd0) begin
      failures++;
      $display("FAIL reset_data: got %h/%h want 0/0", out_0_data, out_1_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_sel0: got %b want 1", in_ready);
    end
    drive(1'b0, 1'b1, 27'd0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_sel1: got %b want 1", in_ready);
    end
`ifdef DEMUX_COUNT_EN
    checks++;
    if (out_0_count !== 16'd0 || out_1_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_count: got %h/%h want 0/0", out_0_count, out_1_count);
    end
`endif
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    drive(1'b1, 1'b0, 27'h4000001, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 27'd0, 1'b1, 1'b1);
    checks++;
    if (out_0_valid !== 1'b1 || out_0_data !== 27'h4000001 || out_1_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_word: got v0=%b d0=%h v1=%b want 1 4000001 0",
               out_0_valid, out_0_data, out_1_valid);
    end
    tick();
    checks++;
    if (out_0_valid !== 1'b0 || out_0_data !== 27'h4000001) begin
      failures++;
      $display("FAIL single_drain: got v0=%b d0=%h want 0 4000001", out_0_valid, out_0_data);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 1'b0, 27'h1234567, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 27'd0, 1'b0, 1'b1);
    checks++;
    if (out_0_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_block0: got v0=%b rdy=%b want 1 0", out_0_valid, in_ready);
    end
    drive(1'b1, 1'b1, 27'h7654321, 1'b0, 1'b1);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_open1: got rdy=%b want 1", in_ready);
    end
    tick();
    drive(1'b0, 1'b1, 27'd0, 1'b0, 1'b1);
    checks++;
    if (out_1_valid !== 1'b1 || out_1_data !== 27'h7654321 ||
        out_0_valid !== 1'b1 || out_0_data !== 27'h1234567) begin
      failures++;
      $display("FAIL bp_isolate: got v1=%b d1=%h v0=%b d0=%h want 1 7654321 1 1234567",
               out_1_valid, out_1_data, out_0_valid, out_0_data);
    end
    tick();
    checks++;
    if (out_1_valid !== 1'b0 || out_0_valid !== 1'b1 || out_0_data !== 27'h1234567) begin
      failures++;
      $display("FAIL bp_hold: got v1=%b v0=%b d0=%h want 0 1 1234567",
               out_1_valid, out_0_valid, out_0_data);
    end
    drive(1'b0, 1'b0, 27'd0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 27'h5a5a5a5, 1'b1, 1'b1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 27'(i), 1'b1, 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_0_valid !== 1'b1 || out_0_data !== 27'(i)) begin
        failures++;
        $display("FAIL b2b_data[%0d]: got v0=%b d0=%h want 1 %h", i, out_0_valid, out_0_data, 27'(i));
      end
    end
    drive(1'b0, 1'b0, 27'd0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_alternating();
    logic [26:0] words [4];
    words[0] = 27'hA; words[1] = 27'hB; words[2] = 27'hC; words[3] = 27'hD;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'(i % 2), words[i], 1'b1, 1'b1);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL alt_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
      checks++;
      if ((i % 2) == 0 ? (out_0_valid !== 1'b1 || out_0_data !== words[i])
                       : (out_1_valid !== 1'b1 || out_1_data !== words[i])) begin
        failures++;
        $display("FAIL alt_data[%0d]: got d0=%h d1=%h want %h on out_%0d",
                 i, out_0_data, out_1_data, words[i], i % 2);
      end
    end
    drive(1'b0, 1'b0, 27'd0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_x_isolation();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'bx, 27'bx, 1'b1, 1'b1);
      tick();
      checks++;
      if (out_0_valid !== 1'b0 || out_1_valid !== 1'b0 ||
          out_0_data !== last0 || out_1_data !== last1) begin
        failures++;
        $display("FAIL x_isolation[%0d]: got v=%b%b d0=%h d1=%h want 00 %h %h",
                 i, out_0_valid, out_1_valid, out_0_data, out_1_data, last0, last1);
      end
    end
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 27'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      exp_rdy = select ? ((exp_q1.size() == 0) || out_1_ready)
                       : ((exp_q0.size() == 0) || out_0_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, exp_rdy);
      end
      checks++;
      if (out_0_valid !== (exp_q0.size() != 0) || out_0_data !== last0) begin
        failures++;
        $display("FAIL rand_out0[%0d]: got %b %h want %b %h",
                 n, out_0_valid, out_0_data, exp_q0.size() != 0, last0);
      end
      checks++;
      if (out_1_valid !== (exp_q1.size() != 0) || out_1_data !== last1) begin
        failures++;
        $display("FAIL rand_out1[%0d]: got %b %h want %b %h",
                 n, out_1_valid, out_1_data, exp_q1.size() != 0, last1);
      end
`ifdef DEMUX_COUNT_EN
      checks++;
      if (out_0_count !== cnt0 || out_1_count !== cnt1) begin
        failures++;
        $display("FAIL rand_count[%0d]: got %h/%h want %h/%h", n, out_0_count, out_1_count, cnt0, cnt1);
      end
`endif
      tick();
    end
    drive(1'b0, 1'b0, 27'd0, 1'b1, 1'b1);
    tick();
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 27'h0000111, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 27'h0000222, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 27'd0, 1'b0, 1'b0);
    checks++;
    if (out_0_valid !== 1'b1 || out_1_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_fill: got %b/%b want 1/1", out_0_valid, out_1_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_0_valid !== 1'b0 || out_1_valid !== 1'b0 ||
        out_0_data !== 27'd0 || out_1_data !== 27'd0) begin
      failures++;
      $display("FAIL midrst_async: got v=%b%b d0=%h d1=%h want 00 0 0",
               out_0_valid, out_1_valid, out_0_data, out_1_data);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef DEMUX_COUNT_EN
  task automatic test_count_wrap();
    int budget;
    apply_reset();
    budget = 0;
    while (cnt1 != 16'hFFFF && budget < 70000) begin
      drive(1'b1, 1'b1, 27'($urandom), 1'b1, 1'b1);
      tick();
      budget++;
    end
    drive(1'b0, 1'b1, 27'd0, 1'b1, 1'b1);
    checks++;
    if (out_1_count !== 16'hFFFF || out_0_count !== 16'd0) begin
      failures++;
      $display("FAIL count_preload: got %h/%h want 0000/ffff", out_0_count, out_1_count);
    end
    tick();
    checks++;
    if (out_1_count !== 16'h0000 || out_0_count !== 16'd0) begin
      failures++;
      $display("FAIL count_wrap: got %h/%h want 0000/0000", out_0_count, out_1_count);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    model_clear();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    select      = 1'b0;
    in_data     = 27'd0;
    out_0_ready = 1'b0;
    out_1_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_alternating();
    test_x_isolation();
    test_random();
    test_mid_reset();
    test_random();
`ifdef DEMUX_COUNT_EN
    test_count_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
